// File: rtl/mem_writer_if.sv
// AXI4 bus bundle shared by the DRAM write and read engines on the DDR port.
// The slave modport is the engine side: it drives AW/W/AR and the B/R ready lines.
interface axi_bus_t;
  logic [3:0]   awid;
  logic [63:0]  awaddr;
  logic [7:0]   awlen;
  logic [2:0]   awsize;
  logic         awvalid;
  logic         awready;

  logic [3:0]   wid;
  logic [511:0] wdata;
  logic [63:0]  wstrb;
  logic         wlast;
  logic         wvalid;
  logic         wready;

  logic [3:0]   bid;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;

  logic [3:0]   arid;
  logic [63:0]  araddr;
  logic [7:0]   arlen;
  logic [2:0]   arsize;
  logic         arvalid;
  logic         arready;

  logic [3:0]   rid;
  logic [511:0] rdata;
  logic [1:0]   rresp;
  logic         rlast;
  logic         rvalid;
  logic         rready;

  modport slave (
    output awid, awaddr, awlen, awsize, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport master (
    input  awid, awaddr, awlen, awsize, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/mem_writer.sv
// DRAM performance-test write engine: writes a seed-derived pattern over a beat region,
// one AXI4 burst at a time, never crossing 4 KB. Optional MEM_WRITER_PERF_CNT_EN adds busy_cycles.
//
// state | meaning
// IDLE  | waiting for enable_q
// START | latch run parameters, clear counters
// AW    | present burst address
// W     | stream burst data beats
// B     | wait for write response, advance region pointer
// DONE  | run finished, hold until enable_q drops
module mem_writer #(
  parameter int MAX_BURST = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] start_addr,
  input  logic [31:0] write_len,
  input  logic [31:0] pattern_seed,
  input  logic        enable,
  output logic        done,
  output logic [15:0] wr_err_cnt,
  output logic [31:0] busy_cycles,
  axi_bus_t.slave     axi
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    AW    = 3'd2,
    W     = 3'd3,
    B     = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [6:0] MAX_B = 7'(MAX_BURST);

  state_t      state, state_nxt;
  logic        enable_q;
  logic [29:0] curr_addr;
  logic [29:0] len_q;
  logic [31:0] seed_q;
  logic [29:0] written_cnt;
  logic [7:0]  beat_cnt;
  logic [7:0]  awlen_q;

  logic [29:0] remaining;
  logic [6:0]  to_4k;
  logic [6:0]  cap;
  logic [6:0]  burst;
  logic [7:0]  awlen_c;
  logic [29:0] beat_idx;
  logic [29:0] written_nxt;
  logic        last_beat;
  logic        run_complete;

  // Burst sizing: never past the end of the region, MAX_BURST, or the next 4 KB line.
  always_comb begin
    remaining = len_q - written_cnt;
    to_4k     = 7'd64 - {1'b0, curr_addr[5:0]};
    cap       = (MAX_B < to_4k) ? MAX_B : to_4k;
    burst     = (remaining < {23'b0, cap}) ? remaining[6:0] : cap;
    awlen_c   = {1'b0, burst - 7'd1};
  end

  assign beat_idx     = curr_addr + {22'b0, beat_cnt};
  assign last_beat    = (beat_cnt == awlen_q);
  assign written_nxt  = written_cnt + {22'b0, awlen_q} + 30'd1;
  assign run_complete = (written_nxt >= len_q);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (enable_q) state_nxt = START;
      START: state_nxt = (write_len[29:0] == 30'd0) ? DONE : AW;
      AW:    if (axi.awready) state_nxt = W;
      W:     if (axi.wready && last_beat) state_nxt = B;
      B:     if (axi.bvalid) state_nxt = run_complete ? DONE : AW;
      DONE:  if (!enable_q) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    done        = 1'b0;
    case (state)
      AW:      axi.awvalid = 1'b1;
      W:       axi.wvalid  = 1'b1;
      B:       axi.bready  = 1'b1;
      DONE:    done        = 1'b1;
      default: ;
    endcase
  end

  // Run datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q    <= 1'b0;
      curr_addr   <= '0;
      len_q       <= '0;
      seed_q      <= '0;
      written_cnt <= '0;
      beat_cnt    <= '0;
      awlen_q     <= '0;
      wr_err_cnt  <= '0;
    end else begin
      enable_q <= enable;
      case (state)
        START: begin
          curr_addr   <= start_addr[29:0];
          len_q       <= write_len[29:0];
          seed_q      <= pattern_seed;
          written_cnt <= '0;
          beat_cnt    <= '0;
          wr_err_cnt  <= '0;
        end
        AW: begin
          if (axi.awready) awlen_q <= awlen_c;
        end
        W: begin
          if (axi.wready) begin
            beat_cnt <= last_beat ? 8'd0 : beat_cnt + 8'd1;
          end
        end
        B: begin
          if (axi.bvalid) begin
            curr_addr   <= curr_addr + {22'b0, awlen_q} + 30'd1;
            written_cnt <= written_nxt;
            if (axi.bresp != 2'b00 && wr_err_cnt != 16'hFFFF) begin
              wr_err_cnt <= wr_err_cnt + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MEM_WRITER_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_cycles <= '0;
    end else if (state == START) begin
      busy_cycles <= '0;
    end else if ((state == AW || state == W || state == B) && busy_cycles != 32'hFFFF_FFFF) begin
      busy_cycles <= busy_cycles + 32'd1;
    end
  end
`else
  assign busy_cycles = '0;
`endif

  assign axi.awid   = '0;
  assign axi.awaddr = {4'b0, 24'b0, curr_addr, 6'b0};
  assign axi.awlen  = awlen_c;
  assign axi.awsize = 3'b110;

  // Lane i carries the seed XOR the beat index with the lane number in the low nibble.
  always_comb begin
    axi.wdata = '0;
    for (int i = 0; i < 16; i++) begin
      axi.wdata[32*i +: 32] = seed_q ^ {beat_idx[27:0], 4'(i)};
    end
  end

  assign axi.wid   = '0;
  assign axi.wstrb = '1;
  assign axi.wlast = last_beat;

  assign axi.arid    = '0;
  assign axi.araddr  = '0;
  assign axi.arlen   = '0;
  assign axi.arsize  = '0;
  assign axi.arvalid = 1'b0;
  assign axi.rready  = 1'b0;

  logic unused_ok;
  assign unused_ok = ^{start_addr[31:30], write_len[31:30], axi.bid, axi.arready,
                       axi.rid, axi.rdata, axi.rresp, axi.rlast, axi.rvalid};

endmodule
